instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the control decoder.
- Holds the program counter, issues word reads to instruction memory using a req/ack handshake, and latches the returned word into an instruction register.
- Presents the full instruction, plus its 4-bit opcode field, to the control decoder and the register-file stage.
- Applies PC redirects (branch/jump) computed downstream when the issued instruction is consumed.

Parameters:
- INST_WIDTH, 16, instruction word width; opcode = instruction[INST_WIDTH-1:INST_WIDTH-4].
- PC_WIDTH, 8, word-addressed program counter width.
- RESET_PC, 0, PC value loaded on reset and on flush.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_req  output  1  read request to instruction memory.
- imem_addr  output  PC_WIDTH  read word address.
- imem_ack  input  1  read data valid this cycle.
- imem_rdata  input  INST_WIDTH  read data.
- stall  input  1  downstream cannot accept the issued instruction this cycle.
- branch_taken  input  1  issued instruction is a taken branch.
- branch_offset  input  PC_WIDTH  signed word offset for branches.
- jump  input  1  issued instruction is a jump.
- jump_target  input  PC_WIDTH  absolute jump target.
- flush  input  1  synchronous restart from RESET_PC.
- instruction  output  INST_WIDTH  instruction register.
- opcode  output  4  top 4 bits of instruction, to control decoder.
- inst_valid  output  1  instruction/opcode valid.
- pc  output  PC_WIDTH  address of the word in instruction (or being fetched).

Behaviour:
- Reset (async, any state):
  - State = FETCH_IDLE; pc = RESET_PC; instruction = 0; opcode = 0.
  - inst_valid = 0; imem_req = 0; imem_addr = RESET_PC.
- States:
  - FETCH_IDLE: imem_req = 0. Next edge goes to FETCH (one idle cycle after reset or flush).
  - FETCH: imem_req = 1, imem_addr = pc; req and addr are held stable until ack. On an edge with imem_ack = 1, latch imem_rdata into instruction and go to ISSUE. Zero-wait memory (ack in the first FETCH cycle) is legal.
  - ISSUE: inst_valid = 1; imem_req = 0; instruction is held stable while stall = 1. On an edge with stall = 0, the instruction is consumed:
    - pc is updated to next_pc;
    - inst_valid drops;
    - state goes to FETCH.
  - DRAIN: entered when flush arrives in FETCH with a request outstanding. imem_req stays at 1 until ack; the returned data is discarded. Then pc = RESET_PC and state goes to FETCH_IDLE.
- next_pc:
  - jump = 1 → jump_target.
  - else branch_taken = 1 → pc + 1 + branch_offset, modulo 2^PC_WIDTH.
  - else pc + 1, wrapping from all-ones to 0.
  - jump has priority over branch_taken.
  - Redirect inputs are sampled only on the consume edge and ignored otherwise.
- Per-cycle throughput: minimum 2 cycles per instruction with zero-wait memory (FETCH + ISSUE).
- flush:
  - In FETCH_IDLE or ISSUE: pc = RESET_PC, inst_valid = 0, state goes to FETCH_IDLE.
  - In FETCH without ack: go to DRAIN.
  - In FETCH with ack on the same edge: data is dropped and state goes to FETCH_IDLE with pc = RESET_PC.
  - flush has priority over consume/redirect.
- imem_ack outside FETCH/DRAIN is ignored.
- opcode always equals instruction[INST_WIDTH-1:INST_WIDTH-4], including after reset (0).

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, adds outputs:
  - issued_count (32 bits): increments on each consume edge;
  - stall_count (32 bits): increments on each cycle in ISSUE with stall = 1.
- Both counters reset to 0 on reset and on flush, and saturate at all-ones.
- When undefined, neither port nor counters exist and behaviour is otherwise identical.

Test Plan:
- Reset release, zero-wait memory returning word 0x2123 at address 0:
  - imem_req rises 1 cycle after release with imem_addr = 0;
  - inst_valid = 1 with instruction = 0x2123, opcode = 0x2;
  - pc advances to 1 after consume.
- Memory ack delayed 3 cycles:
  - imem_req and imem_addr stay stable for all 3 cycles;
  - instruction is latched only on the ack edge.
- pc = 5, branch_taken = 1, branch_offset = 0xFD (-3), stall = 0 → next fetch address is 3.
- jump and branch_taken both set, jump_target = 0x40, branch_offset = 4 → next fetch address is 0x40.
- Wrap and stall:
  - pc = 0xFF, no redirect → next fetch address is 0x00;
  - stall held 4 cycles in ISSUE → instruction unchanged and pc unchanged for all 4 cycles.
- flush asserted in FETCH, ack arriving 2 cycles later with data 0xFFFF:
  - data is never presented and inst_valid stays 0;
  - next request is to RESET_PC;
  - separately, async reset pulsed mid-ISSUE clears inst_valid immediately.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, reads instruction memory over req/ack, presents the word to decode. Optional FETCH_PERF_CNT_EN adds issue/stall counters.
// Latency: one idle cycle after reset/flush, then FETCH (>=1 cycle) + ISSUE (>=1 cycle) per instruction.
// Backpressure: stall holds the instruction in ISSUE; memory wait states hold req/addr stable until ack.
module instruction_fetch #(
    parameter int                  INST_WIDTH = 16,
    parameter int                  PC_WIDTH   = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic                  imem_ack,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [PC_WIDTH-1:0]   branch_offset,
    input  logic                  jump,
    input  logic [PC_WIDTH-1:0]   jump_target,
    input  logic                  flush,
    output logic [INST_WIDTH-1:0] instruction,
    output logic [3:0]            opcode,
    output logic                  inst_valid,
    output logic [PC_WIDTH-1:0]   pc
`ifdef FETCH_PERF_CNT_EN
   ,output logic [31:0]           issued_count,
    output logic [31:0]           stall_count
`endif
);

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH      = 2'd1,
        ISSUE      = 2'd2,
        DRAIN      = 2'd3
    } state_t;

    localparam logic [PC_WIDTH-1:0] LP_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    state_t                r_state;
    logic [PC_WIDTH-1:0]   r_pc;
    logic [PC_WIDTH-1:0]   r_addr;
    logic [INST_WIDTH-1:0] r_inst;
    logic                  r_req;
    logic                  r_vld;

    logic                  w_consume;
    logic [PC_WIDTH-1:0]   w_next_pc;

    // flush outranks consume, so a flushed instruction never redirects the PC
    assign w_consume = (r_state == ISSUE) && !stall && !flush;

    always_comb begin
        w_next_pc = r_pc + LP_ONE;
        if (jump) begin
            w_next_pc = jump_target;
        end else if (branch_taken) begin
            w_next_pc = r_pc + LP_ONE + branch_offset;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FETCH_IDLE;
            r_pc    <= RESET_PC;
            r_addr  <= RESET_PC;
            r_inst  <= '0;
            r_req   <= 1'b0;
            r_vld   <= 1'b0;
        end else begin
            case (r_state)
                FETCH_IDLE: begin
                    if (flush) begin
                        r_pc <= RESET_PC;
                    end else begin
                        r_state <= FETCH;
                        r_req   <= 1'b1;
                        r_addr  <= r_pc;
                    end
                end
                FETCH: begin
                    if (flush) begin
                        // an outstanding read must still complete before restarting
                        if (imem_ack) begin
                            r_state <= FETCH_IDLE;
                            r_req   <= 1'b0;
                            r_pc    <= RESET_PC;
                        end else begin
                            r_state <= DRAIN;
                        end
                    end else if (imem_ack) begin
                        r_inst  <= imem_rdata;
                        r_vld   <= 1'b1;
                        r_req   <= 1'b0;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (flush) begin
                        r_vld   <= 1'b0;
                        r_pc    <= RESET_PC;
                        r_state <= FETCH_IDLE;
                    end else if (w_consume) begin
                        r_vld   <= 1'b0;
                        r_pc    <= w_next_pc;
                        r_addr  <= w_next_pc;
                        r_req   <= 1'b1;
                        r_state <= FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        r_req   <= 1'b0;
                        r_pc    <= RESET_PC;
                        r_state <= FETCH_IDLE;
                    end
                end
                default: begin
                    r_state <= FETCH_IDLE;
                    r_req   <= 1'b0;
                    r_vld   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign instruction = r_inst;
    assign opcode      = r_inst[INST_WIDTH-1 -: 4];
    assign inst_valid  = r_vld;
    assign pc          = r_pc;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_issued_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_issued_cnt <= '0;
            r_stall_cnt  <= '0;
        end else if (flush) begin
            r_issued_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (w_consume && (r_issued_cnt != '1)) begin
                r_issued_cnt <= r_issued_cnt + 32'd1;
            end
            if ((r_state == ISSUE) && stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign issued_count = r_issued_cnt;
    assign stall_count  = r_stall_cnt;
`endif

endmodule
